// File: rtl/prefix_queue.sv
// Decode front end: strips EXTEND/INDEX/INHINT/RELINT prefix words, applies
// INDEX offsets and queues resolved instructions for the decoder.
module prefix_queue #(
    parameter int unsigned WIDTH      = 15,
    parameter int unsigned PC_W       = 12,
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned MAX_PREFIX = 3
) (
    input  logic             clock,
    input  logic             rst_l,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] instr,
    input  logic [PC_W-1:0]  pc,
    input  logic [WIDTH-1:0] index_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_instr,
    output logic             out_ext,
    output logic [PC_W-1:0]  out_pc,
    output logic             out_err,
    output logic             inhibit
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PFX_W = (MAX_PREFIX > 0) ? $clog2(MAX_PREFIX + 1) : 1;

    localparam logic [WIDTH-1:0] OP_EXTEND = WIDTH'(6);
    localparam logic [WIDTH-1:0] OP_INHINT = WIDTH'(4);
    localparam logic [WIDTH-1:0] OP_RELINT = WIDTH'(3);

    typedef struct packed {
        logic [WIDTH-1:0] instr;
        logic             ext;
        logic [PC_W-1:0]  pc;
        logic             err;
    } entry_t;

    logic             ext_pend_q, ext_pend_d;
    logic             idx_pend_q, idx_pend_d;
    logic [WIDTH-1:0] idx_val_q,  idx_val_d;
    logic [PFX_W-1:0] pfx_cnt_q,  pfx_cnt_d;
    logic             inhibit_q,  inhibit_d;
    logic [CNT_W-1:0] count_q,    count_d;
    logic [PTR_W-1:0] wr_ptr_q,   wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q,   rd_ptr_d;
    entry_t           mem_q [DEPTH];
    entry_t           mem_d [DEPTH];

    logic [WIDTH-1:0] eff;
    logic             is_extend;
    logic             is_inhint;
    logic             is_relint;
    logic             is_index;
    logic             accept;
    logic             pop;
    logic             push;
    entry_t           push_entry;
    entry_t           head;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Resolve the presented word against pending INDEX state and classify it.
    always_comb begin
        eff       = idx_pend_q ? WIDTH'(instr + idx_val_q) : instr;
        is_extend = ~ext_pend_q & (eff == OP_EXTEND);
        is_inhint = ~ext_pend_q & (eff == OP_INHINT);
        is_relint = ~ext_pend_q & (eff == OP_RELINT);
        is_index  = (eff[WIDTH-1 -: 3] == 3'd5) & (ext_pend_q | (eff[11:10] == 2'b00));
    end

    assign in_ready  = rst_l & ~flush & (count_q != CNT_W'(DEPTH));
    assign out_valid = (count_q != '0);
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Prefix state machine, FIFO bookkeeping and inhibit tracking.
    always_comb begin
        ext_pend_d = ext_pend_q;
        idx_pend_d = idx_pend_q;
        idx_val_d  = idx_val_q;
        pfx_cnt_d  = pfx_cnt_q;
        inhibit_d  = inhibit_q;
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        mem_d      = mem_q;
        push       = 1'b0;
        push_entry = '0;

        if (accept) begin
            if ((is_extend | is_index) && (pfx_cnt_q == PFX_W'(MAX_PREFIX))) begin
                push       = 1'b1;
                push_entry = '{instr: eff, ext: ext_pend_q, pc: pc, err: 1'b1};
                ext_pend_d = 1'b0;
                idx_pend_d = 1'b0;
                idx_val_d  = '0;
                pfx_cnt_d  = '0;
            end else if (is_extend) begin
                ext_pend_d = 1'b1;
                idx_pend_d = 1'b0;
                pfx_cnt_d  = pfx_cnt_q + PFX_W'(1);
            end else if (is_inhint || is_relint) begin
                inhibit_d  = is_inhint;
                ext_pend_d = 1'b0;
                idx_pend_d = 1'b0;
                idx_val_d  = '0;
                pfx_cnt_d  = '0;
            end else if (is_index) begin
                // ext_pend is deliberately kept so an extended INDEX still marks its target
                idx_pend_d = 1'b1;
                idx_val_d  = index_data;
                pfx_cnt_d  = pfx_cnt_q + PFX_W'(1);
            end else begin
                push       = 1'b1;
                push_entry = '{instr: eff, ext: ext_pend_q, pc: pc, err: 1'b0};
                ext_pend_d = 1'b0;
                idx_pend_d = 1'b0;
                pfx_cnt_d  = '0;
            end
        end

        if (push) begin
            mem_d[wr_ptr_q] = push_entry;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // Flush drops queued work and prefix context but keeps the inhibit state.
        if (flush) begin
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            ext_pend_d = 1'b0;
            idx_pend_d = 1'b0;
            idx_val_d  = '0;
            pfx_cnt_d  = '0;
        end
    end

    always_ff @(posedge clock or negedge rst_l) begin
        if (!rst_l) begin
            ext_pend_q <= 1'b0;
            idx_pend_q <= 1'b0;
            idx_val_q  <= '0;
            pfx_cnt_q  <= '0;
            inhibit_q  <= 1'b0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            ext_pend_q <= ext_pend_d;
            idx_pend_q <= idx_pend_d;
            idx_val_q  <= idx_val_d;
            pfx_cnt_q  <= pfx_cnt_d;
            inhibit_q  <= inhibit_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            mem_q      <= mem_d;
        end
    end

    assign head      = mem_q[rd_ptr_q];
    assign out_instr = head.instr;
    assign out_ext   = head.ext;
    assign out_pc    = head.pc;
    assign out_err   = head.err;
    assign inhibit   = inhibit_q;

endmodule

// File: doc/prefix_queue.md
# prefix_queue

Front end of the decode stage. Accepts fetched instruction words over a valid/ready handshake and consumes the EXTEND, INDEX, INHINT and RELINT prefix words. Applies any pending INDEX offset to the following word, then queues each resolved instruction, with its extracode flag and PC, in a DEPTH-entry buffer that `decode` drains. Unlike the single-register EXTEND/INDEX tracking in `decode`, this block handles chained INDEX sequences, enforces a prefix-length limit, holds the interrupt-inhibit state, and is parametrised in width and buffer depth.

## Interface
- WIDTH, 15: instruction and index data width; opcode field is bits [WIDTH-1:WIDTH-3].
- PC_W, 12: PC width.
- DEPTH, 2: output buffer entries (≥1).
- MAX_PREFIX, 3: maximum consecutive prefix words before a fault entry is generated.

Ports:
- clock  in  1  clock
- rst_l  in  1  asynchronous active-low reset
- flush  in  1  synchronous clear of buffer and prefix state
- in_valid  in  1  word on instr/pc/index_data is valid
- in_ready  out  1  block accepts the word this cycle
- instr  in  WIDTH  raw fetched word
- pc  in  PC_W  address of instr
- index_data  in  WIDTH  memory operand of instr, sampled only when the accepted word is an INDEX
- out_valid  out  1  buffer head is valid
- out_ready  in  1  decode consumes the head
- out_instr  out  WIDTH  effective (indexed) instruction
- out_ext  out  1  head is an extracode
- out_pc  out  PC_W  pc of the head word
- out_err  out  1  head is a prefix-limit fault entry
- inhibit  out  1  interrupt-inhibit state

## Operation
- State: ext_pend, idx_pend, idx_val[WIDTH-1:0], pfx_cnt, inhibit, FIFO with count.
- Effective word eff = idx_pend ? (instr + idx_val) mod 2^WIDTH : instr. Classification uses eff.
- Prefix words are consumed and never enter the FIFO. Classification of an accepted word:
  - ext_pend=0, eff==0o00006 (EXTEND): ext_pend←1, idx_pend←0.
  - ext_pend=0, eff==0o00004 (INHINT): inhibit←1; all prefix state cleared.
  - ext_pend=0, eff==0o00003 (RELINT): inhibit←0; all prefix state cleared.
  - INDEX: ext_pend=0 with opcode 5 and bits[11:10]==0, or ext_pend=1 with opcode 5. Updates idx_pend←1 and idx_val←index_data. ext_pend is unchanged, so an extended INDEX keeps the next word extracode.
  - Anything else is an instruction. Push {eff, ext_pend, pc, err=0}, then clear ext_pend, idx_pend and pfx_cnt.
- pfx_cnt counts the EXTEND and INDEX words accepted since the last push or clear. If a prefix word is accepted while pfx_cnt==MAX_PREFIX, push {eff, ext_pend, pc, err=1} instead and clear all prefix state.
- in_ready = rst_l & ~flush & (count != DEPTH). Prefix words are also gated by a full buffer.
- out_valid = (count != 0). A pop occurs when out_valid & out_ready.
- flush: clears the FIFO, ext_pend, idx_pend and pfx_cnt. inhibit is kept. Any word presented in the flush cycle is not accepted.

## Timing
- Reset values: out_valid 0, in_ready 0 while rst_l low, out_instr/out_ext/out_pc/out_err 0, inhibit 0, all prefix state 0.
- Latency: an instruction accepted in cycle N is at the head with out_valid=1 in cycle N+1 when the buffer was empty. No combinational in→out bypass.
- Prefix state updates at the accepting edge. The word accepted in cycle N+1 sees the updated state.
- inhibit changes at the edge that accepts INHINT or RELINT.
- Push and pop in the same cycle: count unchanged, order preserved.
- When full, in_ready=0 even if a pop occurs that cycle.
- Head fields are stable while out_valid=1 and out_ready=0.
- Reset mid-sequence discards pending EXTEND and INDEX state.

## Test plan
- EXTEND 0o00006 then 0o70005 → one entry in the cycle after the second accept: out_instr 0o70005, out_ext 1, out_pc equal to the pc of the second word.
- INDEX 0o50020 with index_data 0o00003, then 0o30100 → out_instr 0o30103, out_ext 0, no entry for the INDEX.
- EXTEND, then 0o50020 with index_data 0o00002, then 0o10004 → out_instr 0o10006, out_ext 1. Then 0o30000 → out_ext 0.
- INHINT 0o00004 → no entry, inhibit 1 next cycle. Flush → inhibit stays 1. RELINT 0o00003 → inhibit 0.
- DEPTH=2, out_ready=0, three instruction words presented → in_ready drops after the second. Raise out_ready → third accepted and entries emerge in order.
- MAX_PREFIX=3, four INDEX words 0o50000 each with index_data 0 → the fourth produces out_err=1 with out_instr 0o50000. The next word 0o30005 → out_err 0, out_instr 0o30005.
